// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer sharing one adder; ADDER_ARB_SUB_EN adds per-requester subtract
module adder_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  localparam int IDW   = NREQ > 1 ? $clog2(NREQ) : 1,
  localparam int CW    = SETTLE > 1 ? $clog2(SETTLE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      res,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  busy,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_out,
  input  logic                  add_cout,
  input  logic                  add_ovf
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [IDW-1:0] r_ptr, r_owner, r_id, w_win;
  logic [CW-1:0] r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic [WIDTH-1:0] r_add_a, r_add_b, r_res;
  logic r_add_cin, r_cout, r_ovf, w_found, w_grant, w_sub;
`ifdef ADDER_ARB_SUB_EN
  assign w_sub = req_sub[w_win];
`else
  assign w_sub = 1'b0;
`endif
  assign w_grant = r_state == IDLE && w_found;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: grant from IDLE, count out the settle time, one DONE cycle
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_found ? WAIT : IDLE) :
             r_state == WAIT ? (r_cnt == '0 ? DONE : WAIT) : IDLE;
  end
  // first asserted request at or above the pointer, wrapping; scanned downward so the nearest wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IDW'((int'(r_ptr) + k) % NREQ);
      end
  end
  // operand capture on grant, result capture at the end of the settle window
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_gnt <= '0; r_ptr <= '0; r_owner <= '0; r_id <= '0; r_cnt <= '0;
      r_add_a <= '0; r_add_b <= '0; r_add_cin <= 1'b0;
      r_res <= '0; r_cout <= 1'b0; r_ovf <= 1'b0;
    end else begin
      r_gnt <= '0;
      if (w_grant) begin
        r_gnt     <= NREQ'(1) << w_win;
        r_add_a   <= req_a[int'(w_win)*WIDTH +: WIDTH];
        r_add_b   <= w_sub ? ~req_b[int'(w_win)*WIDTH +: WIDTH] : req_b[int'(w_win)*WIDTH +: WIDTH];
        r_add_cin <= w_sub | req_cin[w_win];
        r_owner   <= w_win;
        r_ptr     <= w_win == IDW'(NREQ - 1) ? '0 : w_win + 1'b1;
        r_cnt     <= CW'(SETTLE - 1);
      end else if (r_state == WAIT) begin
        if (r_cnt == '0) begin
          r_res  <= add_out;
          r_cout <= add_cout;
          r_ovf  <= add_ovf;
          r_id   <= r_owner;
        end else r_cnt <= r_cnt - 1'b1;
      end
    end
  assign gnt      = r_gnt;
  assign done     = r_state == DONE;
  assign busy     = r_state != IDLE;
  assign done_id  = r_id;
  assign res      = r_res;
  assign res_cout = r_cout;
  assign res_ovf  = r_ovf;
  assign add_a    = r_add_a;
  assign add_b    = r_add_b;
  assign add_cin  = r_add_cin;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of adder_arbiter with a behavioural 32-bit adder attached
module tb_adder_arbiter;
  localparam int W = 32, N = 4, S = 2;
  logic clk = 0, reset = 1;
  logic [N-1:0] req = '0, req_cin = '0, gnt;
  logic [N*W-1:0] req_a = '0, req_b = '0;
`ifdef ADDER_ARB_SUB_EN
  logic [N-1:0] req_sub = '0;
`endif
  logic done, res_cout, res_ovf, busy, add_cin, add_cout, add_ovf;
  logic [1:0] done_id;
  logic [W-1:0] res, add_a, add_b, add_out;
  int nerr = 0, nchk = 0, cyc = 0;

  adder_arbiter #(.WIDTH(W), .NREQ(N), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .gnt(gnt), .done(done), .done_id(done_id), .res(res), .res_cout(res_cout), .res_ovf(res_ovf),
    .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_out(add_out), .add_cout(add_cout), .add_ovf(add_ovf));

  assign {add_cout, add_out} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
  assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_out[W-1] != add_a[W-1]);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    do begin tick(); n++; end while (gnt == '0 && n < 20);
    chk({tag, "_gnt_seen"}, gnt != '0, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!done && n < 20);
    chk({tag, "_done_seen"}, done, 1);
  endtask

  task automatic set_lanes(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    req_a = {N{a}};
    req_b = {N{b}};
    req_cin = {N{cin}};
`ifdef ADDER_ARB_SUB_EN
    req_sub = {N{sub}};
`endif
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] mask, input int id,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    int t;
    req = mask;
    wait_gnt(tag);
    chk({tag, "_gnt"}, gnt, 64'(1) << id);
    t = cyc;
    req = '0;
    wait_done(tag);
    chk({tag, "_lat"}, cyc - t, S);
    chk({tag, "_id"}, done_id, id);
    chk({tag, "_res"}, res, er);
    chk({tag, "_cout"}, res_cout, ec);
    chk({tag, "_ovf"}, res_ovf, eo);
  endtask

  initial begin
    int tg, tp;
    tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    chk("rst_add_a", add_a, 0);
    reset = 0;
    // single operation, requester 0
    set_lanes(32'd5, 32'd7, 1'b0, 1'b0);
    req = 4'b0001;
    tick();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_busy", busy, 1);
    chk("t1_add_a", add_a, 5);
    req = '0;
    tick();
    chk("t1_gnt_low", gnt, 0);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_res", res, 12);
    chk("t1_cout", res_cout, 0);
    chk("t1_ovf", res_ovf, 0);
    chk("t1_id", done_id, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    // all requesting continuously from a fresh pointer
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(i * 100);
      req_b[i*W +: W] = 32'(i);
    end
    req_cin = '0;
    req = 4'b1111;
    tp = 0;
    for (int op = 0; op < 8; op++) begin
      wait_gnt("rr");
      chk("rr_gnt", gnt, 64'(1) << (op % N));
      tg = cyc;
      if (op > 0) chk("rr_spacing", tg - tp, S + 2);
      tp = tg;
      wait_done("rr");
      chk("rr_lat", cyc - tg, S);
      chk("rr_id", done_id, op % N);
      chk("rr_res", res, (op % N) * 101);
    end
    req = '0;
    tick();
    // carry and signed overflow boundaries
    set_lanes(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op("carry", 4'b0001, 0, 32'h0, 1'b1, 1'b0);
    set_lanes(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op("ovf", 4'b0001, 0, 32'h8000_0000, 1'b0, 1'b1);
    // reset in the middle of WAIT
    set_lanes(32'h55, 32'h1, 1'b0, 1'b0);
    req = 4'b0100;
    wait_gnt("mid");
    chk("mid_gnt", gnt, 4'b0100);
    req = '0;
    tick();
    chk("mid_busy", busy, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ovf", res_ovf, 0);
    tick(); reset = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_done", done, 0);
    end
    set_lanes(32'd9, 32'd4, 1'b1, 1'b0);
    do_op("ptr0", 4'b1100, 2, 32'd14, 1'b0, 1'b0);
    // pointer now 3; 0110 grants 1 then 2; operand change during WAIT is ignored
    req_a[1*W +: W] = 32'd10; req_b[1*W +: W] = 32'd1;
    req_a[2*W +: W] = 32'd20; req_b[2*W +: W] = 32'd2;
    req_cin = '0;
    req = 4'b0110;
    wait_gnt("wrap1");
    chk("wrap1_gnt", gnt, 4'b0010);
    req_a[1*W +: W] = 32'd999;
    wait_done("wrap1");
    chk("wrap1_res", res, 11);
    chk("wrap1_id", done_id, 1);
    wait_gnt("wrap2");
    chk("wrap2_gnt", gnt, 4'b0100);
    req = '0;
    wait_done("wrap2");
    chk("wrap2_res", res, 22);
    chk("wrap2_id", done_id, 2);
    // subtract when enabled, plain add otherwise
    set_lanes(32'd3, 32'd5, 1'b0, 1'b1);
`ifdef ADDER_ARB_SUB_EN
    do_op("sub", 4'b0001, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
`else
    do_op("add35", 4'b0001, 0, 32'd8, 1'b0, 1'b0);
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
